alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- User-interface and alarm sequencer for the alarm-clock datapath.
- Decodes three push-buttons into a time-set / alarm-set mode state machine.
- Drives the time counter's load interface: set_time, key_hour, key_minute.
- Holds the alarm time, compares it against the running hour/minute/second, and controls the ring, stop and snooze sequence.

Parameters:
- RING_SECS, default 60: tick pulses a ring lasts before it stops by itself (1..63).
- SNOOZE_MIN, default 5: minutes added to the alarm target on snooze (1..59).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- tick  in  1  one-cycle pulse, once per second, synchronous to clk
- btn_mode, btn_up, btn_stop  in  1 each  button levels, already synchronised and debounced
- alarm_en  in  1  alarm enable switch (level)
- cur_hour, cur_minute, cur_second  in  6 each  running time, binary
- set_time  out  1  one-cycle load strobe to the time counter
- key_hour, key_minute  out  6 each  load value; valid while set_time=1
- alm_hour, alm_minute  out  6 each  stored alarm time
- mode  out  3  current state encoding, for the display
- ringing  out  1  alarm sounding
- snoozed  out  1  snooze target active

Behaviour:
- Reset (rst=0): asynchronous; all flops clear immediately.
  - Reset values: mode=RUN, set_time=0, key_hour=0, key_minute=0, alm_hour=6, alm_minute=0, ringing=0, snoozed=0, edit registers=0.
  - Button history flops reset to 0, so a button held through reset produces no event.
  - ring counter=0, arm=1.
- Button events:
  - Each button has a registered history flop; an event is one cycle on a 0->1 level transition.
  - Holding a button produces exactly one event.
- State encoding: RUN=0, SET_H=1, SET_M=2, ALM_H=3, ALM_M=4.
- State transitions:
  - RUN + mode event: load edit_h/edit_m from cur_hour/cur_minute, go to SET_H.
  - SET_H: up event -> edit_h = (edit_h+1) mod 24. Mode event -> SET_M.
  - SET_M: up event -> edit_m = (edit_m+1) mod 60. Mode event -> pulse set_time for exactly 1 cycle with key_hour=edit_h, key_minute=edit_m, then go to ALM_H.
  - ALM_H: up event -> alm_hour = (alm_hour+1) mod 24; also clears snoozed. Mode event -> ALM_M.
  - ALM_M: up event -> alm_minute = (alm_minute+1) mod 60; also clears snoozed. Mode event -> RUN.
  - btn_stop in any SET/ALM state: abort to RUN. No set_time pulse; edits already made to alm_* are kept.
  - Edit values are held while no events occur.
  - key_* hold their last value when set_time=0.
- Alarm target:
  - snoozed=0: target = (alm_hour, alm_minute).
  - snoozed=1: target = (snz_hour, snz_minute).
- Alarm trigger:
  - Condition: mode=RUN, alarm_en=1, ringing=0, arm=1, cur_hour/cur_minute equal the target, cur_second=0.
  - Effect: ringing=1 on the next edge, arm=0, ring counter cleared.
  - arm returns to 1 in any cycle where cur_second!=0, giving one trigger per matching minute.
- While ringing=1:
  - Each tick increments the ring counter. When the count reaches RING_SECS, ringing=0 and snoozed=0.
  - btn_stop event: ringing=0, snoozed=0.
  - btn_up event (snooze):
    - ringing=0, snoozed=1.
    - snz_minute = cur_minute+SNOOZE_MIN; if the sum is >=60, subtract 60 and carry 1 hour.
    - snz_hour wraps 23->0.
    - Snoozing again re-targets from the current time.
  - Mode events are ignored.
  - Simultaneous stop and up: stop wins.
  - Simultaneous tick reaching RING_SECS and an up event: snooze wins.
- alarm_en=0: ringing and snoozed clear on the next edge; no trigger can occur.
- Trigger is suppressed in all non-RUN states, even when the time matches.
- All arithmetic is 6-bit.
- cur_* inputs are in range by contract; no range checking is done.

Test Plan:
- Reset: rst=0 mid-ring, holding btn_mode=1 -> immediately ringing=0, mode=0, alm=06:00. Release rst with btn_mode still high -> no mode event.
- Set time: mode event, up x3 in SET_H from cur 22:10 (wraps: 23,0,1), mode event, up x2, mode event -> single-cycle set_time with key_hour=1, key_minute=12; mode=3.
- Alarm edit with wrap: ALM_M with alm_minute=59, one up event -> alm_minute=0, alm_hour unchanged. Mode event -> mode=0.
- Ring and timeout: alarm 06:00, alarm_en=1, cur reaches 06:00:00 held for 100 cycles -> exactly one ringing rise. RING_SECS=60 ticks later -> ringing=0, no retrigger while cur_minute=0.
- Snooze wrap: ring at 23:58, up event -> ringing=0, snoozed=1, target 00:03. cur=00:03:00 -> ringing=1. Then btn_stop and btn_up in the same cycle -> ringing=0, snoozed=0.
- Enable and mode gating: time matches while mode=SET_H -> no ring. While ringing, alarm_en=0 -> ringing=0 next cycle.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm-clock user interface: button-driven time/alarm set FSM plus the
// alarm compare, ring timeout and snooze sequencer.
module alarm_ctrl #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_stop,
    input  logic       alarm_en,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic       set_time,
    output logic [5:0] key_hour,
    output logic [5:0] key_minute,
    output logic [5:0] alm_hour,
    output logic [5:0] alm_minute,
    output logic [2:0] mode,
    output logic       ringing,
    output logic       snoozed
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        ALM_H = 3'd3,
        ALM_M = 3'd4
    } state_t;

    localparam logic [5:0] RING_CNT = 6'(RING_SECS);
    localparam logic [6:0] SNZ_ADD  = 7'(SNOOZE_MIN);

    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_STOP = 2;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim - 6'd1) ? 6'd0 : v + 6'd1;
    endfunction

    state_t     state_reg, state_next;
    logic [2:0] btn_rel_reg, btn_rel_next;
    logic [2:0] btn_lvl, btn_ev;
    logic [5:0] edit_h_reg, edit_h_next, edit_m_reg, edit_m_next;
    logic [5:0] key_hour_reg, key_hour_next, key_minute_reg, key_minute_next;
    logic       set_time_reg, set_time_next;
    logic [5:0] alm_hour_reg, alm_hour_next, alm_minute_reg, alm_minute_next;
    logic [5:0] snz_hour_reg, snz_hour_next, snz_minute_reg, snz_minute_next;
    logic       ringing_reg, ringing_next, snoozed_reg, snoozed_next;
    logic [5:0] ring_cnt_reg, ring_cnt_next, ring_cnt_inc;
    logic       arm_reg, arm_next;
    logic       target_match, trigger;
    logic [6:0] snz_sum;
    logic [5:0] snz_hour_calc, snz_minute_calc;

    assign btn_lvl = {btn_stop, btn_up, btn_mode};

    // History flops hold "was released last cycle"; clearing them in reset
    // means a button held through reset cannot produce an event.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            assign btn_rel_next[gi] = ~btn_lvl[gi];
            assign btn_ev[gi]       = btn_lvl[gi] & btn_rel_reg[gi];
        end
    endgenerate

    assign target_match = snoozed_reg
        ? (cur_hour == snz_hour_reg && cur_minute == snz_minute_reg)
        : (cur_hour == alm_hour_reg && cur_minute == alm_minute_reg);

    assign trigger = (state_reg == RUN) && alarm_en && !ringing_reg && arm_reg
                     && target_match && (cur_second == 6'd0);

    assign ring_cnt_inc = ring_cnt_reg + 6'd1;

    // Sum kept one bit wider so large snooze values cannot alias below 60.
    assign snz_sum = {1'b0, cur_minute} + SNZ_ADD;
    always_comb begin
        snz_minute_calc = snz_sum[5:0];
        snz_hour_calc   = cur_hour;
        if (snz_sum >= 7'd60) begin
            snz_minute_calc = 6'(snz_sum - 7'd60);
            snz_hour_calc   = inc_wrap(cur_hour, 6'd24);
        end
    end

    always_comb begin
        state_next      = state_reg;
        edit_h_next     = edit_h_reg;
        edit_m_next     = edit_m_reg;
        key_hour_next   = key_hour_reg;
        key_minute_next = key_minute_reg;
        set_time_next   = 1'b0;
        alm_hour_next   = alm_hour_reg;
        alm_minute_next = alm_minute_reg;
        snz_hour_next   = snz_hour_reg;
        snz_minute_next = snz_minute_reg;
        ringing_next    = ringing_reg;
        snoozed_next    = snoozed_reg;
        ring_cnt_next   = ring_cnt_reg;
        arm_next        = arm_reg;

        if (cur_second != 6'd0) begin
            arm_next = 1'b1;
        end

        if (ringing_reg) begin
            if (btn_ev[B_STOP]) begin
                ringing_next = 1'b0;
                snoozed_next = 1'b0;
            end else if (btn_ev[B_UP]) begin
                ringing_next    = 1'b0;
                snoozed_next    = 1'b1;
                snz_hour_next   = snz_hour_calc;
                snz_minute_next = snz_minute_calc;
            end else if (tick) begin
                ring_cnt_next = ring_cnt_inc;
                if (ring_cnt_inc == RING_CNT) begin
                    ringing_next = 1'b0;
                    snoozed_next = 1'b0;
                end
            end
        end else if (trigger) begin
            ringing_next  = 1'b1;
            arm_next      = 1'b0;
            ring_cnt_next = 6'd0;
        end

        // Buttons belong to the ring sequencer while the alarm sounds.
        if (!ringing_reg) begin
            case (state_reg)
                RUN: begin
                    if (btn_ev[B_MODE]) begin
                        edit_h_next = cur_hour;
                        edit_m_next = cur_minute;
                        state_next  = SET_H;
                    end
                end
                SET_H: begin
                    if (btn_ev[B_STOP])      state_next  = RUN;
                    else if (btn_ev[B_MODE]) state_next  = SET_M;
                    else if (btn_ev[B_UP])   edit_h_next = inc_wrap(edit_h_reg, 6'd24);
                end
                SET_M: begin
                    if (btn_ev[B_STOP]) begin
                        state_next = RUN;
                    end else if (btn_ev[B_MODE]) begin
                        set_time_next   = 1'b1;
                        key_hour_next   = edit_h_reg;
                        key_minute_next = edit_m_reg;
                        state_next      = ALM_H;
                    end else if (btn_ev[B_UP]) begin
                        edit_m_next = inc_wrap(edit_m_reg, 6'd60);
                    end
                end
                ALM_H: begin
                    if (btn_ev[B_STOP]) begin
                        state_next = RUN;
                    end else if (btn_ev[B_MODE]) begin
                        state_next = ALM_M;
                    end else if (btn_ev[B_UP]) begin
                        alm_hour_next = inc_wrap(alm_hour_reg, 6'd24);
                        snoozed_next  = 1'b0;
                    end
                end
                ALM_M: begin
                    if (btn_ev[B_STOP] || btn_ev[B_MODE]) begin
                        state_next = RUN;
                    end else if (btn_ev[B_UP]) begin
                        alm_minute_next = inc_wrap(alm_minute_reg, 6'd60);
                        snoozed_next    = 1'b0;
                    end
                end
                default: state_next = RUN;
            endcase
        end

        if (!alarm_en) begin
            ringing_next = 1'b0;
            snoozed_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= RUN;
            btn_rel_reg    <= 3'b000;
            edit_h_reg     <= 6'd0;
            edit_m_reg     <= 6'd0;
            key_hour_reg   <= 6'd0;
            key_minute_reg <= 6'd0;
            set_time_reg   <= 1'b0;
            alm_hour_reg   <= 6'd6;
            alm_minute_reg <= 6'd0;
            snz_hour_reg   <= 6'd0;
            snz_minute_reg <= 6'd0;
            ringing_reg    <= 1'b0;
            snoozed_reg    <= 1'b0;
            ring_cnt_reg   <= 6'd0;
            arm_reg        <= 1'b1;
        end else begin
            state_reg      <= state_next;
            btn_rel_reg    <= btn_rel_next;
            edit_h_reg     <= edit_h_next;
            edit_m_reg     <= edit_m_next;
            key_hour_reg   <= key_hour_next;
            key_minute_reg <= key_minute_next;
            set_time_reg   <= set_time_next;
            alm_hour_reg   <= alm_hour_next;
            alm_minute_reg <= alm_minute_next;
            snz_hour_reg   <= snz_hour_next;
            snz_minute_reg <= snz_minute_next;
            ringing_reg    <= ringing_next;
            snoozed_reg    <= snoozed_next;
            ring_cnt_reg   <= ring_cnt_next;
            arm_reg        <= arm_next;
        end
    end

    assign set_time   = set_time_reg;
    assign key_hour   = key_hour_reg;
    assign key_minute = key_minute_reg;
    assign alm_hour   = alm_hour_reg;
    assign alm_minute = alm_minute_reg;
    assign mode       = state_reg;
    assign ringing    = ringing_reg;
    assign snoozed    = snoozed_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: minute-of-day behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alarm_ctrl;

    localparam int RING_SECS  = 60;
    localparam int SNOOZE_MIN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_stop = 1'b0;
    logic       alarm_en = 1'b0;
    logic [5:0] cur_hour = 6'd0, cur_minute = 6'd0, cur_second = 6'd0;
    logic       set_time;
    logic [5:0] key_hour, key_minute, alm_hour, alm_minute;
    logic [2:0] mode;
    logic       ringing, snoozed;

    alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_stop(btn_stop),
        .alarm_en(alarm_en),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_time(set_time), .key_hour(key_hour), .key_minute(key_minute),
        .alm_hour(alm_hour), .alm_minute(alm_minute), .mode(mode),
        .ringing(ringing), .snoozed(snoozed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tcount = 0;
    int rises = 0;
    int st_pulses = 0;
    bit prev_ring = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Model: times as minutes of the day, buttons as previous levels.
    int m_mode, m_eh, m_em, m_kh, m_km, m_ah, m_am, m_snz_t, m_cnt;
    bit m_set, m_ring, m_snz, m_arm, m_pm, m_pu, m_ps;
    bit me, ue, se, was_ring;
    int now_min, tgt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_eh = 0; m_em = 0; m_kh = 0; m_km = 0;
            m_ah = 6; m_am = 0; m_snz_t = 0; m_cnt = 0;
            m_set = 0; m_ring = 0; m_snz = 0; m_arm = 1;
            m_pm = 1; m_pu = 1; m_ps = 1;
        end else begin
            me = btn_mode && !m_pm;
            ue = btn_up && !m_pu;
            se = btn_stop && !m_ps;
            m_pm = btn_mode; m_pu = btn_up; m_ps = btn_stop;
            was_ring = m_ring;
            now_min = cur_hour * 60 + cur_minute;
            tgt = m_snz ? m_snz_t : m_ah * 60 + m_am;
            m_set = 0;
            if (was_ring) begin
                if (se) begin
                    m_ring = 0; m_snz = 0;
                end else if (ue) begin
                    m_ring = 0; m_snz = 1;
                    m_snz_t = (now_min + SNOOZE_MIN) % 1440;
                end else if (tick) begin
                    m_cnt++;
                    if (m_cnt >= RING_SECS) begin m_ring = 0; m_snz = 0; end
                end
            end else if (m_mode == 0 && alarm_en && m_arm && cur_second == 0 && now_min == tgt) begin
                m_ring = 1; m_cnt = 0; m_arm = 0;
            end
            if (cur_second != 0) m_arm = 1;
            if (!was_ring) begin
                if (m_mode == 0) begin
                    if (me) begin m_eh = cur_hour; m_em = cur_minute; m_mode = 1; end
                end else if (se) begin
                    m_mode = 0;
                end else if (me) begin
                    if (m_mode == 2) begin m_set = 1; m_kh = m_eh; m_km = m_em; end
                    m_mode = (m_mode + 1) % 5;
                end else if (ue) begin
                    case (m_mode)
                        1: m_eh = (m_eh + 1) % 24;
                        2: m_em = (m_em + 1) % 60;
                        3: begin m_ah = (m_ah + 1) % 24; m_snz = 0; end
                        default: begin m_am = (m_am + 1) % 60; m_snz = 0; end
                    endcase
                end
            end
            if (!alarm_en) begin m_ring = 0; m_snz = 0; end
        end
    end

    always @(negedge clk) begin
        chk("mode", int'(mode), m_mode);
        chk("set_time", int'(set_time), int'(m_set));
        chk("key_hour", int'(key_hour), m_kh);
        chk("key_minute", int'(key_minute), m_km);
        chk("alm_hour", int'(alm_hour), m_ah);
        chk("alm_minute", int'(alm_minute), m_am);
        chk("ringing", int'(ringing), int'(m_ring));
        chk("snoozed", int'(snoozed), int'(m_snz));
        if (ringing && !prev_ring) rises++;
        prev_ring = ringing;
        if (set_time) st_pulses++;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            tick = (tcount % 4 == 3);
            tcount++;
        end
    endtask

    task automatic press(input int which);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_up = 1'b1;
        else btn_stop = 1'b1;
        cyc(2);
        btn_mode = 1'b0; btn_up = 1'b0; btn_stop = 1'b0;
        cyc(1);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 6'(h); cur_minute = 6'(m); cur_second = 6'(s);
    endtask

    initial begin
        cyc(2);
        rst = 1'b1;
        cyc(2);
        chk("reset_mode", int'(mode), 0);
        chk("reset_alm_hour", int'(alm_hour), 6);
        chk("reset_ringing", int'(ringing), 0);

        // Time set: 22:10 -> hours 23,0,1 -> minutes 11,12 -> load 01:12
        set_cur(22, 10, 5);
        press(0);
        chk("enter_set_h", int'(mode), 1);
        for (int i = 0; i < 3; i++) press(1);
        press(0);
        for (int i = 0; i < 2; i++) press(1);
        press(0);
        chk("set_pulses", st_pulses, 1);
        chk("key_hour_val", int'(key_hour), 1);
        chk("key_minute_val", int'(key_minute), 12);
        chk("mode_alm_h", int'(mode), 3);

        // Alarm minute wrap 59 -> 0 with hour untouched
        press(0);
        for (int i = 0; i < 59; i++) press(1);
        chk("alm_min_59", int'(alm_minute), 59);
        press(1);
        chk("alm_min_wrap", int'(alm_minute), 0);
        chk("alm_hour_kept", int'(alm_hour), 6);
        press(0);
        chk("back_to_run", int'(mode), 0);

        // Ring at 06:00:00 and self-timeout with no retrigger
        alarm_en = 1'b1;
        set_cur(6, 0, 0);
        cyc(100);
        chk("ring_once", rises, 1);
        chk("still_ringing", int'(ringing), 1);
        cyc(200);
        chk("ring_timeout", int'(ringing), 0);
        chk("no_retrigger", rises, 1);

        // Program alarm 23:58 (passes through SET_M, one more load pulse)
        alarm_en = 1'b0;
        press(0); press(0); press(0);
        for (int i = 0; i < 17; i++) press(1);
        press(0);
        for (int i = 0; i < 58; i++) press(1);
        press(0);
        chk("alm_2358_h", int'(alm_hour), 23);
        chk("alm_2358_m", int'(alm_minute), 58);

        // Snooze across midnight: target 00:03
        alarm_en = 1'b1;
        set_cur(23, 57, 10); cyc(2);
        set_cur(23, 58, 0); cyc(3);
        chk("ring_2358", int'(ringing), 1);
        press(1);
        chk("snooze_ring", int'(ringing), 0);
        chk("snooze_flag", int'(snoozed), 1);
        set_cur(0, 3, 10); cyc(2);
        set_cur(0, 3, 0); cyc(3);
        chk("ring_0003", int'(ringing), 1);
        btn_stop = 1'b1; btn_up = 1'b1;
        cyc(2);
        btn_stop = 1'b0; btn_up = 1'b0;
        cyc(1);
        chk("stop_wins_ring", int'(ringing), 0);
        chk("stop_wins_snz", int'(snoozed), 0);

        // No trigger outside RUN; triggers once back in RUN within the minute
        set_cur(10, 0, 30); cyc(2);
        press(0);
        set_cur(23, 58, 0); cyc(10);
        chk("no_ring_set_h", int'(ringing), 0);
        press(2);
        chk("abort_run", int'(mode), 0);
        chk("abort_no_load", st_pulses, 2);
        chk("ring_after_abort", int'(ringing), 1);
        alarm_en = 1'b0;
        cyc(1);
        chk("en_off_clears", int'(ringing), 0);

        // Asynchronous reset mid-ring with btn_mode held
        alarm_en = 1'b1;
        set_cur(23, 57, 30); cyc(2);
        set_cur(23, 58, 0); cyc(3);
        chk("ring_pre_reset", int'(ringing), 1);
        btn_mode = 1'b1;
        cyc(1);
        #1 rst = 1'b0;
        #1;
        chk("async_ringing", int'(ringing), 0);
        chk("async_mode", int'(mode), 0);
        chk("async_alm_hour", int'(alm_hour), 6);
        chk("async_alm_min", int'(alm_minute), 0);
        cyc(2);
        rst = 1'b1;
        cyc(5);
        chk("held_no_event", int'(mode), 0);
        btn_mode = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
